clk_monitor: RTL

Synthesizable checker that sits at the receiving end of a generated clock. It samples an asynchronous monitored clock on the system clock and measures each monitored period in system-clock cycles. It flags periods that fall outside a programmed window and detects a stopped clock. It also reports lock after a run of good periods, so benches and on-chip logic can qualify any clock source before using it.

---
 rtl/clk_monitor.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/clk_monitor.sv
// Measures the period of an asynchronous monitored clock in system-clock cycles.
// Flags out-of-window and stopped clocks, and reports lock after a run of good periods.
module clk_monitor #(
  parameter int CNT_W      = 16,
  parameter int PERIOD_MIN = 4,
  parameter int PERIOD_MAX = 6,
  parameter int TIMEOUT    = 64,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_clk_i,
  input  logic             enable_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid_o,
  output logic             too_fast_o,
  output logic             too_slow_o,
  output logic             stopped_o,
  output logic             locked_o,
  output logic [CNT_W-1:0] edge_cnt_o
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(PERIOD_MAX);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [RUN_W-1:0] LOCK_C    = RUN_W'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE} state_t;

  state_t           state, state_nxt;
  logic             s1, s2, s3;
  logic             rise;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [RUN_W-1:0] run, run_nxt, run_inc;
  logic             locked_nxt;
  logic [CNT_W-1:0] period_nxt, edge_nxt;
  logic             valid_nxt;
  logic             set_fast, set_slow, set_stop;

  // The rise lags the real edge by a constant 2-3 cycles, which cancels out of periods.
  assign rise    = s2 & ~s3;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  assign run_inc = (run == LOCK_C) ? run : run + 1'b1;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    run_nxt    = run;
    locked_nxt = locked_o;
    period_nxt = period_o;
    edge_nxt   = edge_cnt_o;
    valid_nxt  = 1'b0;
    set_fast   = 1'b0;
    set_slow   = 1'b0;
    set_stop   = 1'b0;

    if (!enable_i) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      run_nxt    = '0;
      locked_nxt = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_nxt    = '0;
          run_nxt    = '0;
          locked_nxt = 1'b0;
          state_nxt  = ACQUIRE;
        end
        ACQUIRE: begin
          if (rise) begin
            cnt_nxt   = CNT_W'(1);
            state_nxt = MEASURE;
          end else if (cnt == TIMEOUT_C) begin
            set_stop = 1'b1;
            cnt_nxt  = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        MEASURE: begin
          // A rise landing on the timeout cycle is still a valid measurement.
          if (rise) begin
            period_nxt = cnt;
            valid_nxt  = 1'b1;
            edge_nxt   = edge_cnt_o + 1'b1;
            cnt_nxt    = CNT_W'(1);
            if (cnt < MIN_C) begin
              set_fast   = 1'b1;
              run_nxt    = '0;
              locked_nxt = 1'b0;
            end else if (cnt > MAX_C) begin
              set_slow   = 1'b1;
              run_nxt    = '0;
              locked_nxt = 1'b0;
            end else begin
              run_nxt = run_inc;
              if (run_inc == LOCK_C) locked_nxt = 1'b1;
            end
          end else if (cnt == TIMEOUT_C) begin
            set_stop   = 1'b1;
            run_nxt    = '0;
            locked_nxt = 1'b0;
            cnt_nxt    = '0;
            state_nxt  = ACQUIRE;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      s1             <= 1'b0;
      s2             <= 1'b0;
      s3             <= 1'b0;
      cnt            <= '0;
      run            <= '0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
      too_fast_o     <= 1'b0;
      too_slow_o     <= 1'b0;
      stopped_o      <= 1'b0;
      locked_o       <= 1'b0;
      edge_cnt_o     <= '0;
    end else begin
      state          <= state_nxt;
      s1             <= mon_clk_i;
      s2             <= s1;
      s3             <= s2;
      cnt            <= cnt_nxt;
      run            <= run_nxt;
      period_o       <= period_nxt;
      period_valid_o <= valid_nxt;
      // Sticky flags: a set in the same cycle as clear_i wins.
      too_fast_o     <= set_fast | (too_fast_o & ~clear_i);
      too_slow_o     <= set_slow | (too_slow_o & ~clear_i);
      stopped_o      <= set_stop | (stopped_o & ~clear_i);
      locked_o       <= locked_nxt;
      edge_cnt_o     <= edge_nxt;
    end
  end

endmodule
